// File: rtl/atax_call_pkg.sv
// Shared types and constants for the atax call/return initiator.
//   ADDR_W      : width of each argument base address
//   CNT_W       : width of the issued/completed totals and watchdog counter
//   atax_args_t : one argument set (A, x, y, tmp)
//   atax_state_e: issue FSM states
package atax_call_pkg;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned CNT_W  = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] A;
        logic [ADDR_W-1:0] x;
        logic [ADDR_W-1:0] y;
        logic [ADDR_W-1:0] tmp;
    } atax_args_t;

    typedef enum logic {
        IDLE,
        DRIVE
    } atax_state_e;

endpackage

// File: rtl/atax_cmd_fifo.sv
// Synchronous show-ahead FIFO of atax argument sets.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   push, din    : write din when push is high (caller guarantees !full)
//   pop          : discard head (caller guarantees !empty)
//   full, empty  : occupancy flags, derived from registered pointers only
//   head         : current head entry, valid whenever !empty
module atax_cmd_fifo
    import atax_call_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  atax_args_t din,
    output logic       full,
    output logic       empty,
    output atax_args_t head
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    atax_args_t      mem_q [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]     wr_ptr_q;
    logic [AW:0]     rd_ptr_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/atax_call_driver.sv
// Caller-side initiator for the atax component call/return interface.
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready     : host argument-set push into the command FIFO
//   cmd_A/x/y/tmp           : argument base addresses
//   call_start/call_busy    : component call handshake (accept = start && !busy)
//   call_A/x/y/tmp          : argument set held stable while call_start is high
//   ret_done/ret_stall      : component return handshake (accept = done && !stall)
//   rsp_valid/ready/tag     : one-entry in-order completion stream
//   inflight                : calls issued but not yet returned
//   issued_cnt/completed_cnt: wrapping totals
//   err_timeout/err_spurious: sticky watchdog / unexpected-done flags
module atax_call_driver
    import atax_call_pkg::*;
#(
    parameter int unsigned CMD_DEPTH    = 4,
    parameter int unsigned MAX_INFLIGHT = 8,
    parameter int unsigned TAG_W        = 16,
    parameter int unsigned TIMEOUT      = 1000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_A,
    input  logic [ADDR_W-1:0] cmd_x,
    input  logic [ADDR_W-1:0] cmd_y,
    input  logic [ADDR_W-1:0] cmd_tmp,
    output logic              call_start,
    input  logic              call_busy,
    output logic [ADDR_W-1:0] call_A,
    output logic [ADDR_W-1:0] call_x,
    output logic [ADDR_W-1:0] call_y,
    output logic [ADDR_W-1:0] call_tmp,
    input  logic              ret_done,
    output logic              ret_stall,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic [7:0]        inflight,
    output logic [CNT_W-1:0]  issued_cnt,
    output logic [CNT_W-1:0]  completed_cnt,
    output logic              err_timeout,
    output logic              err_spurious
);

    localparam logic [8:0]       MAX_IF = 9'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] TO     = 32'(TIMEOUT);

    atax_state_e      state_q, state_d;
    atax_args_t       args_q, args_d;
    logic [7:0]       inflight_q, inflight_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] completed_q, completed_d;
    logic [TAG_W-1:0] retire_tag_q, retire_tag_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic             err_timeout_q, err_timeout_d;
    logic             err_spurious_q, err_spurious_d;

    logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
    atax_args_t fifo_din, fifo_head;
    logic       accept, done_acc, retire, wd_clear;
    logic [8:0] inflight_ext;

    assign fifo_din  = '{A: cmd_A, x: cmd_x, y: cmd_y, tmp: cmd_tmp};
    // Gated with reset so cmd_ready reads 0 while reset is held.
    assign cmd_ready = !fifo_full && !reset;
    assign fifo_push = cmd_valid && cmd_ready;

    atax_cmd_fifo #(
        .DEPTH(CMD_DEPTH)
    ) u_fifo (
        .clock(clock),
        .reset(reset),
        .push (fifo_push),
        .pop  (fifo_pop),
        .din  (fifo_din),
        .full (fifo_full),
        .empty(fifo_empty),
        .head (fifo_head)
    );

    assign inflight_ext = {1'b0, inflight_q};
    assign accept       = (state_q == DRIVE) && !call_busy;
    assign ret_stall    = rsp_valid_q && !rsp_ready;
    assign done_acc     = ret_done && !ret_stall;
    assign retire       = done_acc && (inflight_q != '0);
    assign wd_clear     = done_acc || (inflight_q == '0);

    always_comb begin
        state_d        = state_q;
        fifo_pop       = 1'b0;
        args_d         = args_q;
        inflight_d     = inflight_q + {7'b0, accept} - {7'b0, retire};
        issued_d       = issued_q + {31'b0, accept};
        completed_d    = completed_q + {31'b0, retire};
        retire_tag_d   = retire_tag_q + {{(TAG_W-1){1'b0}}, retire};
        rsp_valid_d    = rsp_valid_q;
        rsp_tag_d      = rsp_tag_q;
        wd_d           = wd_q;
        err_timeout_d  = err_timeout_q;
        err_spurious_d = err_spurious_q || (done_acc && (inflight_q == '0));

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty && (inflight_ext < MAX_IF)) begin
                    fifo_pop = 1'b1;
                    state_d  = DRIVE;
                end
            end
            DRIVE: begin
                // Chain the next call when the post-accept count still has room.
                if (accept) begin
                    if (!fifo_empty && ((inflight_ext + 9'd1) < MAX_IF)) fifo_pop = 1'b1;
                    else                                                  state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (fifo_pop) args_d = fifo_head;

        // A retire reload takes priority over a drain in the same cycle.
        if (retire) begin
            rsp_valid_d = 1'b1;
            rsp_tag_d   = retire_tag_q;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        if (wd_clear) begin
            wd_d = '0;
        end else begin
            if (wd_q != '1) wd_d = wd_q + 1'b1;
            if ((TO != '0) && (wd_q >= TO - 1'b1)) err_timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            args_q         <= '0;
            inflight_q     <= '0;
            issued_q       <= '0;
            completed_q    <= '0;
            retire_tag_q   <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_tag_q      <= '0;
            wd_q           <= '0;
            err_timeout_q  <= 1'b0;
            err_spurious_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            args_q         <= args_d;
            inflight_q     <= inflight_d;
            issued_q       <= issued_d;
            completed_q    <= completed_d;
            retire_tag_q   <= retire_tag_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_tag_q      <= rsp_tag_d;
            wd_q           <= wd_d;
            err_timeout_q  <= err_timeout_d;
            err_spurious_q <= err_spurious_d;
        end
    end

    assign call_start    = (state_q == DRIVE);
    assign call_A        = args_q.A;
    assign call_x        = args_q.x;
    assign call_y        = args_q.y;
    assign call_tmp      = args_q.tmp;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_tag       = rsp_tag_q;
    assign inflight      = inflight_q;
    assign issued_cnt    = issued_q;
    assign completed_cnt = completed_q;
    assign err_timeout   = err_timeout_q;
    assign err_spurious  = err_spurious_q;

endmodule

// File: tb/tb_atax_call_driver.sv
module tb_atax_call_driver;
    import atax_call_pkg::*;

    localparam int unsigned MAXI = 2;
    localparam int unsigned TOUT = 16;
    localparam int unsigned TW   = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready;
    logic [63:0]   cmd_A, cmd_x, cmd_y, cmd_tmp;
    logic          call_start, call_busy;
    logic [63:0]   call_A, call_x, call_y, call_tmp;
    logic          ret_done, ret_stall;
    logic          rsp_valid, rsp_ready;
    logic [TW-1:0] rsp_tag;
    logic [7:0]    inflight;
    logic [31:0]   issued_cnt, completed_cnt;
    logic          err_timeout, err_spurious;

    int errors = 0;
    int checks = 0;

    atax_call_driver #(
        .CMD_DEPTH   (4),
        .MAX_INFLIGHT(MAXI),
        .TAG_W       (TW),
        .TIMEOUT     (TOUT)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_A(cmd_A), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_tmp(cmd_tmp),
        .call_start(call_start), .call_busy(call_busy),
        .call_A(call_A), .call_x(call_x), .call_y(call_y), .call_tmp(call_tmp),
        .ret_done(ret_done), .ret_stall(ret_stall),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
        .inflight(inflight), .issued_cnt(issued_cnt), .completed_cnt(completed_cnt),
        .err_timeout(err_timeout), .err_spurious(err_spurious)
    );

    always #5 clock = ~clock;

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        cmd_valid = 0; cmd_A = '0; cmd_x = '0; cmd_y = '0; cmd_tmp = '0;
        call_busy = 0; ret_done = 0; rsp_ready = 1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1;
        step(); step();
        reset = 0;
        #1;
    endtask

    task automatic push_cmd(input logic [255:0] a);
        cmd_valid = 1;
        {cmd_A, cmd_x, cmd_y, cmd_tmp} = a;
        step();
        cmd_valid = 0;
    endtask

    task automatic wait_issued(input int n, input string name);
        for (int i = 0; i < 50 && issued_cnt != 32'(n); i++) step();
        checks++;
        if (issued_cnt !== 32'(n)) begin
            errors++;
            $display("FAIL %s_wait_issued: issued_cnt=%0d want %0d", name, issued_cnt, n);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        step(); step();
        checks++;
        if ({cmd_ready, call_start, call_A, call_x, call_y, call_tmp, ret_stall, rsp_valid,
             rsp_tag, inflight, issued_cnt, completed_cnt, err_timeout, err_spurious} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b start=%b rv=%b infl=%0d iss=%0d cmp=%0d want all 0",
                     cmd_ready, call_start, rsp_valid, inflight, issued_cnt, completed_cnt);
        end
        reset = 0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_single_call();
        apply_reset();
        push_cmd({64'h1000, 64'h2000, 64'h3000, 64'h4000});
        checks++;
        if (call_start !== 1'b0) begin
            errors++; $display("FAIL single_early_start: got %b want 0", call_start);
        end
        step();
        checks++;
        if (call_start !== 1'b1 ||
            {call_A, call_x, call_y, call_tmp} !== {64'h1000, 64'h2000, 64'h3000, 64'h4000}) begin
            errors++;
            $display("FAIL single_start: start=%b A=%h x=%h y=%h tmp=%h want 1 1000 2000 3000 4000",
                     call_start, call_A, call_x, call_y, call_tmp);
        end
        step();
        checks++;
        if (call_start !== 1'b0 || inflight !== 8'd1 || issued_cnt !== 32'd1) begin
            errors++;
            $display("FAIL single_accept: start=%b infl=%0d iss=%0d want 0 1 1", call_start, inflight, issued_cnt);
        end
        ret_done = 1;
        step();
        ret_done = 0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_tag !== '0 || inflight !== 8'd0 ||
            completed_cnt !== 32'd1 || issued_cnt !== 32'd1) begin
            errors++;
            $display("FAIL single_return: rv=%b tag=%0d infl=%0d iss=%0d cmp=%0d want 1 0 0 1 1",
                     rsp_valid, rsp_tag, inflight, issued_cnt, completed_cnt);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL single_drain: rv=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_busy();
        logic [255:0] a;
        a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        apply_reset();
        call_busy = 1;
        push_cmd(a);
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (call_start !== 1'b1 || {call_A, call_x, call_y, call_tmp} !== a || issued_cnt !== 32'd0) begin
                errors++;
                $display("FAIL busy_hold[%0d]: start=%b iss=%0d args_match=%b want 1 0 1",
                         i, call_start, issued_cnt, {call_A, call_x, call_y, call_tmp} === a);
            end
        end
        call_busy = 0;
        step();
        checks++;
        if (call_start !== 1'b0 || issued_cnt !== 32'd1 || inflight !== 8'd1) begin
            errors++;
            $display("FAIL busy_accept: start=%b iss=%0d infl=%0d want 0 1 1", call_start, issued_cnt, inflight);
        end
        step(); step(); step();
        checks++;
        if (issued_cnt !== 32'd1 || call_start !== 1'b0) begin
            errors++; $display("FAIL busy_no_dup: iss=%0d start=%b want 1 0", issued_cnt, call_start);
        end
    endtask

    task automatic test_inflight_limit();
        int starts;
        starts = 0;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1;
            cmd_A = 64'(i + 1); cmd_x = 64'(i + 11); cmd_y = 64'(i + 21); cmd_tmp = 64'(i + 31);
            step();
            if (call_start) starts++;
        end
        cmd_valid = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (call_start) starts++;
        end
        checks++;
        if (starts != 2 || issued_cnt !== 32'd2 || inflight !== 8'd2) begin
            errors++;
            $display("FAIL limit_count: starts=%0d iss=%0d infl=%0d want 2 2 2", starts, issued_cnt, inflight);
        end
        checks++;
        if (call_start !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL limit_idle: start=%b rdy=%b want 0 1", call_start, cmd_ready);
        end
        ret_done = 1;
        step();
        ret_done = 0;
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (issued_cnt !== 32'd3 || inflight !== 8'd2 || call_start !== 1'b0) begin
            errors++;
            $display("FAIL limit_third: iss=%0d infl=%0d start=%b want 3 2 0", issued_cnt, inflight, call_start);
        end
    endtask

    task automatic test_ret_backpressure();
        apply_reset();
        push_cmd({64'hA, 64'hB, 64'hC, 64'hD});
        push_cmd({64'hE, 64'hF, 64'h10, 64'h11});
        wait_issued(2, "bp");
        rsp_ready = 0;
        ret_done = 1;
        #1;
        checks++;
        if (ret_stall !== 1'b0) begin
            errors++; $display("FAIL bp_first_stall: got %b want 0", ret_stall);
        end
        step();
        checks++;
        if (ret_stall !== 1'b1) begin
            errors++; $display("FAIL bp_second_stall: got %b want 1", ret_stall);
        end
        step();
        ret_done = 0;
        checks++;
        if (inflight !== 8'd1 || completed_cnt !== 32'd1 || rsp_valid !== 1'b1 || rsp_tag !== 4'd0) begin
            errors++;
            $display("FAIL bp_held: infl=%0d cmp=%0d rv=%b tag=%0d want 1 1 1 0",
                     inflight, completed_cnt, rsp_valid, rsp_tag);
        end
        rsp_ready = 1;
        step();
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL bp_drain: rv=%b want 0", rsp_valid);
        end
        ret_done = 1;
        step();
        ret_done = 0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_tag !== 4'd1 || inflight !== 8'd0 || completed_cnt !== 32'd2) begin
            errors++;
            $display("FAIL bp_second_tag: rv=%b tag=%0d infl=%0d cmp=%0d want 1 1 0 2",
                     rsp_valid, rsp_tag, inflight, completed_cnt);
        end
    endtask

    task automatic test_watchdog();
        int early;
        early = 0;
        apply_reset();
        push_cmd({64'h1, 64'h2, 64'h3, 64'h4});
        wait_issued(1, "wd");
        for (int i = 1; i < int'(TOUT); i++) begin
            step();
            if (err_timeout !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            errors++; $display("FAIL wd_early: %0d early cycles with err_timeout=1 want 0", early);
        end
        step();
        checks++;
        if (err_timeout !== 1'b1) begin
            errors++; $display("FAIL wd_fire: err_timeout=%b want 1", err_timeout);
        end
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (err_timeout !== 1'b1) begin
            errors++; $display("FAIL wd_sticky: err_timeout=%b want 1", err_timeout);
        end
        apply_reset();
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++; $display("FAIL wd_reset: err_timeout=%b want 0", err_timeout);
        end
    endtask

    task automatic test_spurious_and_reset();
        apply_reset();
        ret_done = 1;
        step();
        ret_done = 0;
        checks++;
        if (err_spurious !== 1'b1 || rsp_valid !== 1'b0 || inflight !== 8'd0 ||
            completed_cnt !== 32'd0 || issued_cnt !== 32'd0) begin
            errors++;
            $display("FAIL spurious: err=%b rv=%b infl=%0d iss=%0d cmp=%0d want 1 0 0 0 0",
                     err_spurious, rsp_valid, inflight, issued_cnt, completed_cnt);
        end
        push_cmd({64'h100, 64'h200, 64'h300, 64'h400});
        push_cmd({64'h101, 64'h201, 64'h301, 64'h401});
        push_cmd({64'h102, 64'h202, 64'h302, 64'h402});
        wait_issued(2, "rst");
        reset = 1;
        step();
        checks++;
        if ({cmd_ready, call_start, call_A, call_x, call_y, call_tmp, ret_stall, rsp_valid,
             rsp_tag, inflight, issued_cnt, completed_cnt, err_timeout, err_spurious} !== '0) begin
            errors++;
            $display("FAIL midcall_reset: rdy=%b start=%b infl=%0d iss=%0d spur=%b want all 0",
                     cmd_ready, call_start, inflight, issued_cnt, err_spurious);
        end
        reset = 0;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (issued_cnt !== 32'd0 || call_start !== 1'b0) begin
            errors++; $display("FAIL reset_fifo_dropped: iss=%0d start=%b want 0 0", issued_cnt, call_start);
        end
        push_cmd({64'h55, 64'h66, 64'h77, 64'h88});
        step();
        checks++;
        if (call_start !== 1'b1 || call_A !== 64'h55 || call_tmp !== 64'h88) begin
            errors++;
            $display("FAIL post_reset_args: start=%b A=%h tmp=%h want 1 55 88", call_start, call_A, call_tmp);
        end
        step();
        ret_done = 1;
        step();
        ret_done = 0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_tag !== 4'd0) begin
            errors++; $display("FAIL post_reset_tag: rv=%b tag=%0d want 1 0", rsp_valid, rsp_tag);
        end
    endtask

    // Transaction-level reference: argument sets leave in push order, tags count
    // completions modulo 2^TW, and the watchdog counts quiet cycles with work outstanding.
    task automatic test_random();
        atax_args_t q[$];
        atax_args_t got;
        int  m_out, m_iss, m_cmp, m_rtag, m_quiet;
        bit  m_rv, m_to;
        bit  push, acc, dacc, retire;
        m_out = 0; m_iss = 0; m_cmp = 0; m_rtag = 0; m_quiet = 0; m_rv = 0; m_to = 0;
        apply_reset();
        for (int cyc = 0; cyc < 900; cyc++) begin
            if (cyc < 600) begin
                cmd_valid = ($urandom_range(0, 1) == 1);
                cmd_A = {$urandom, $urandom}; cmd_x = {$urandom, $urandom};
                cmd_y = {$urandom, $urandom}; cmd_tmp = {$urandom, $urandom};
                call_busy = ($urandom_range(0, 3) == 0);
                rsp_ready = ($urandom_range(0, 3) != 0);
                ret_done  = (m_out > 0) && ($urandom_range(0, 1) == 1);
            end else begin
                cmd_valid = 0; call_busy = 0; rsp_ready = 1;
                ret_done  = (m_out > 0);
            end
            #1;
            push = cmd_valid && cmd_ready;
            acc  = call_start && !call_busy;
            dacc = ret_done && !ret_stall;
            checks++;
            if (ret_stall !== (m_rv && !rsp_ready)) begin
                errors++;
                $display("FAIL rnd_stall c%0d: got %b want %b", cyc, ret_stall, m_rv && !rsp_ready);
            end
            if (acc) begin
                got = '{A: call_A, x: call_x, y: call_y, tmp: call_tmp};
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rnd_issue_empty c%0d: issue with no command queued", cyc);
                end else begin
                    if (got !== q[0]) begin
                        errors++; $display("FAIL rnd_args c%0d: A=%h want %h", cyc, call_A, q[0].A);
                    end
                    void'(q.pop_front());
                end
            end
            if (push) q.push_back('{A: cmd_A, x: cmd_x, y: cmd_y, tmp: cmd_tmp});
            retire = dacc && (m_out > 0);
            if (retire) begin
                m_rv = 1; m_rtag = m_cmp % (1 << TW); m_cmp++;
            end else if (m_rv && rsp_ready) begin
                m_rv = 0;
            end
            if (dacc || m_out == 0) m_quiet = 0;
            else begin
                m_quiet++;
                if (m_quiet >= int'(TOUT)) m_to = 1;
            end
            m_out = m_out + int'(acc) - int'(retire);
            m_iss = m_iss + int'(acc);
            step();
            checks++;
            if (inflight !== 8'(m_out) || issued_cnt !== 32'(m_iss) || completed_cnt !== 32'(m_cmp)) begin
                errors++;
                $display("FAIL rnd_counts c%0d: infl=%0d iss=%0d cmp=%0d want %0d %0d %0d",
                         cyc, inflight, issued_cnt, completed_cnt, m_out, m_iss, m_cmp);
            end
            checks++;
            if (rsp_valid !== m_rv || (m_rv && rsp_tag !== TW'(m_rtag))) begin
                errors++;
                $display("FAIL rnd_rsp c%0d: rv=%b tag=%0d want %b %0d", cyc, rsp_valid, rsp_tag, m_rv, m_rtag);
            end
            checks++;
            if (err_timeout !== m_to || err_spurious !== 1'b0 || m_out > int'(MAXI)) begin
                errors++;
                $display("FAIL rnd_flags c%0d: to=%b spur=%b out=%0d want %b 0 <=%0d",
                         cyc, err_timeout, err_spurious, m_out, m_to, MAXI);
            end
        end
        checks++;
        if (q.size() != 0 || m_out != 0) begin
            errors++;
            $display("FAIL rnd_drain: queued=%0d outstanding=%0d want 0 0", q.size(), m_out);
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        test_reset();
        test_single_call();
        test_busy();
        test_inflight_limit();
        test_ret_backpressure();
        test_watchdog();
        test_spurious_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
